multicycle_main_control: RTL and testbench

Main control FSM for the multi-cycle RISC-V datapath. It is the producer side of the ALU-control interface: it decodes opcode_i and sequences FETCH/DECODE/EXECUTE/MEM/WB. Each cycle it drives alu_op_o, alu_func3_o and alu_func7_o into the ALU-control decoder, plus all datapath enables. A valid/ready handshake with the unified memory port tolerates variable memory latency.

---
 rtl/rv_ctrl_pkg.sv | 39 +++
 rtl/multicycle_main_control_mem_timeout_ctr.sv | 42 ++++
 rtl/multicycle_main_control.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V main control: opcodes,
// FSM state encoding, ALU-op codes and ALU B-operand select codes.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_MEM_WB,
    S_BRANCH,
    S_TRAP,
    S_ERROR
  } state_t;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // States whose exit back to FETCH marks a completed instruction.
  function automatic logic is_retire_state(input state_t s);
    return (s == S_ALU_WB) || (s == S_MEM_WB) || (s == S_MEM_WR) || (s == S_BRANCH);
  endfunction

endpackage

// File: rtl/multicycle_main_control_mem_timeout_ctr.sv
// Memory wait counter shared by instruction and data requests. It counts
// cycles where a request is outstanding without ready and flags expiry on
// the waiting cycle that would make the count reach MEM_TIMEOUT.
// MEM_TIMEOUT = 0 disables expiry entirely.
module mem_timeout_ctr #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TMO_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [TMO_W-1:0] LAST_WAIT = TMO_W'(MEM_TIMEOUT - 1);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  // Clear on any state change, otherwise count stalled request cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (MEM_TIMEOUT != 0) && inc_i && (cnt_q == LAST_WAIT);

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle RISC-V datapath. Sequences
// FETCH/DECODE/EXECUTE/MEM/WB, drives the ALU-control fields and all
// datapath enables, and handshakes with a variable-latency memory port.
// Optional macro CTRL_PERF_CNT_EN adds cycle_o / instret_o counters.
module multicycle_main_control
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TMO_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode_i,
  input  logic [2:0] func3_i,
  input  logic       func7_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       i_or_d_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       pc_src_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [2:0] alu_func3_o,
  output logic       alu_func7_o,
  output logic       reg_write_o,
  output logic       mem_to_reg_o,
  output logic       illegal_o,
  output logic       bus_err_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] instret_o,
  output logic [31:0] cycle_o
`endif
);

  state_t state_q;
  state_t state_d;
  logic   tmo_expired;
  logic   state_change;

  assign state_change = (state_d != state_q);

  mem_timeout_ctr #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TMO_W      (TMO_W)
  ) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (state_change),
    .inc_i    (mem_req_o && !mem_ready_i),
    .expired_o(tmo_expired)
  );

  // Next-state logic; ready beats a timeout expiring in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready_i)      state_d = S_DECODE;
        else if (tmo_expired) state_d = S_ERROR;
      end
      S_DECODE: begin
        case (opcode_i)
          OPC_R:          state_d = S_EXEC_R;
          OPC_I:          state_d = S_EXEC_I;
          OPC_LW, OPC_SW: state_d = S_MEM_ADDR;
          OPC_BEQ:        state_d = S_BRANCH;
          default:        state_d = S_TRAP;
        endcase
      end
      S_EXEC_R:   state_d = S_ALU_WB;
      S_EXEC_I:   state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_MEM_ADDR: state_d = (opcode_i == OPC_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready_i)      state_d = S_MEM_WB;
        else if (tmo_expired) state_d = S_ERROR;
      end
      S_MEM_WR: begin
        if (mem_ready_i)      state_d = S_FETCH;
        else if (tmo_expired) state_d = S_ERROR;
      end
      S_MEM_WB:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore output decode; only FETCH also looks at mem_ready_i.
  always_comb begin
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    i_or_d_o        = 1'b0;
    ir_write_o      = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_src_o        = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRCB_RS2;
    alu_op_o        = ALUOP_ADD;
    alu_func3_o     = 3'b000;
    alu_func7_o     = 1'b0;
    reg_write_o     = 1'b0;
    mem_to_reg_o    = 1'b0;
    illegal_o       = 1'b0;
    bus_err_o       = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o = SRCB_IMM;
      end
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_RS2;
        alu_op_o    = ALUOP_R;
        alu_func3_o = func3_i;
        alu_func7_o = func7_i;
      end
      S_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_func3_o = func3_i;
      end
      S_ALU_WB: begin
        reg_write_o = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_req_o = 1'b1;
        i_or_d_o  = 1'b1;
      end
      S_MEM_WR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        i_or_d_o  = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_src_b_o     = SRCB_RS2;
        alu_op_o        = ALUOP_BR;
        pc_write_cond_o = 1'b1;
        pc_src_o        = 1'b1;
      end
      S_TRAP:  illegal_o = 1'b1;
      S_ERROR: bus_err_o = 1'b1;
      default: ;
    endcase
  end

  // State register; reset abandons any pending request and restarts fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_q;
  logic [31:0] cycle_d;
  logic [31:0] instret_q;
  logic [31:0] instret_d;

  // Free-running cycle count and retired-instruction count.
  always_comb begin
    cycle_d   = cycle_q + 32'd1;
    instret_d = instret_q;
    if ((state_d == S_FETCH) && is_retire_state(state_q)) begin
      instret_d = instret_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_o   = cycle_q;
  assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control. Each instruction is planned as a list
// of datapath phases with bench-chosen memory wait counts; every cycle the
// outputs are compared against the control word the phase should produce.
module tb_multicycle_main_control;

  localparam int TMO = 4;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC_R = 2, P_EXEC_I = 3, P_ALU_WB = 4,
                 P_MEM_ADDR = 5, P_MEM_RD = 6, P_MEM_WR = 7, P_MEM_WB = 8,
                 P_BRANCH = 9, P_TRAP = 10, P_ERROR = 11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] func3;
    logic       func7;
    logic       reg_write;
    logic       mem_to_reg;
    logic       illegal;
    logic       bus_err;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode_i = '0;
  logic [2:0] func3_i = '0;
  logic       func7_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       mem_req_o, mem_we_o, i_or_d_o, ir_write_o, pc_write_o;
  logic       pc_write_cond_o, pc_src_o, alu_src_a_o;
  logic [1:0] alu_src_b_o, alu_op_o;
  logic [2:0] alu_func3_o;
  logic       alu_func7_o, reg_write_o, mem_to_reg_o, illegal_o, bus_err_o;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instret_o, cycle_o;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  multicycle_main_control #(.MEM_TIMEOUT(TMO), .TMO_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .opcode_i       (opcode_i),
    .func3_i        (func3_i),
    .func7_i        (func7_i),
    .mem_ready_i    (mem_ready_i),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .i_or_d_o       (i_or_d_o),
    .ir_write_o     (ir_write_o),
    .pc_write_o     (pc_write_o),
    .pc_write_cond_o(pc_write_cond_o),
    .pc_src_o       (pc_src_o),
    .alu_src_a_o    (alu_src_a_o),
    .alu_src_b_o    (alu_src_b_o),
    .alu_op_o       (alu_op_o),
    .alu_func3_o    (alu_func3_o),
    .alu_func7_o    (alu_func7_o),
    .reg_write_o    (reg_write_o),
    .mem_to_reg_o   (mem_to_reg_o),
    .illegal_o      (illegal_o),
    .bus_err_o      (bus_err_o)
`ifdef CTRL_PERF_CNT_EN
    ,
    .instret_o      (instret_o),
    .cycle_o        (cycle_o)
`endif
  );

  // Control word each datapath phase must present.
  function automatic ctrl_t expectVec(input int ph, input logic rdy);
    ctrl_t v;
    v = '0;
    case (ph)
      P_FETCH:    begin v.mem_req = 1; v.alu_src_b = 2'b01; v.ir_write = rdy; v.pc_write = rdy; end
      P_DECODE:   v.alu_src_b = 2'b10;
      P_EXEC_R:   begin v.alu_src_a = 1; v.alu_op = 2'b10; v.func3 = func3_i; v.func7 = func7_i; end
      P_EXEC_I:   begin v.alu_src_a = 1; v.alu_src_b = 2'b10; v.func3 = func3_i; end
      P_ALU_WB:   v.reg_write = 1;
      P_MEM_ADDR: begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
      P_MEM_RD:   begin v.mem_req = 1; v.i_or_d = 1; end
      P_MEM_WR:   begin v.mem_req = 1; v.mem_we = 1; v.i_or_d = 1; end
      P_MEM_WB:   begin v.reg_write = 1; v.mem_to_reg = 1; end
      P_BRANCH:   begin v.alu_src_a = 1; v.alu_op = 2'b01; v.pc_write_cond = 1; v.pc_src = 1; end
      P_TRAP:     v.illegal = 1;
      P_ERROR:    v.bus_err = 1;
      default:    v = '0;
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string tag, input ctrl_t exp);
    ctrl_t got;
    got = {mem_req_o, mem_we_o, i_or_d_o, ir_write_o, pc_write_o, pc_write_cond_o,
           pc_src_o, alu_src_a_o, alu_src_b_o, alu_op_o, alu_func3_o, alu_func7_o,
           reg_write_o, mem_to_reg_o, illegal_o, bus_err_o};
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %05h expected %05h", tag, got, exp);
    end
  endtask

  // One clock: drive ready, check the phase's control word, advance.
  task automatic applyStimulus(input int ph, input logic rdy, input string tag);
    mem_ready_i = rdy;
    #1;
    checkOutput(tag, expectVec(ph, rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    mem_ready_i = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready_i = 1'b0;
    #1;
    checkOutput("reset_state", expectVec(P_FETCH, 1'b0));
  endtask

  // Request phase with a planned wait; reports whether the timeout hit.
  task automatic memPhase(input int ph, input int waitCycles, input string tag, output bit timedOut);
    timedOut = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      if (i == waitCycles) begin
        applyStimulus(ph, 1'b1, tag);
        return;
      end
      applyStimulus(ph, 1'b0, tag);
    end
    timedOut = 1'b1;
  endtask

  task automatic holdAndReset(input int ph, input string tag);
    for (int i = 0; i < 3; i++) applyStimulus(ph, 1'($urandom_range(0, 1)), tag);
    doReset();
  endtask

  task automatic runInstr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input int fw, input int dw);
    bit to;
    opcode_i = op;
    func3_i  = f3;
    func7_i  = f7;
    memPhase(P_FETCH, fw, "fetch", to);
    if (to) begin holdAndReset(P_ERROR, "fetch_timeout"); return; end
    applyStimulus(P_DECODE, 1'($urandom_range(0, 1)), "decode");
    if (op == OP_R) begin
      applyStimulus(P_EXEC_R, 1'($urandom_range(0, 1)), "exec_r");
      applyStimulus(P_ALU_WB, 1'($urandom_range(0, 1)), "alu_wb");
    end else if (op == OP_I) begin
      applyStimulus(P_EXEC_I, 1'($urandom_range(0, 1)), "exec_i");
      applyStimulus(P_ALU_WB, 1'($urandom_range(0, 1)), "alu_wb");
    end else if (op == OP_LW) begin
      applyStimulus(P_MEM_ADDR, 1'($urandom_range(0, 1)), "mem_addr");
      memPhase(P_MEM_RD, dw, "mem_rd", to);
      if (to) begin holdAndReset(P_ERROR, "rd_timeout"); return; end
      applyStimulus(P_MEM_WB, 1'($urandom_range(0, 1)), "mem_wb");
    end else if (op == OP_SW) begin
      applyStimulus(P_MEM_ADDR, 1'($urandom_range(0, 1)), "mem_addr");
      memPhase(P_MEM_WR, dw, "mem_wr", to);
      if (to) begin holdAndReset(P_ERROR, "wr_timeout"); return; end
    end else if (op == OP_BEQ) begin
      applyStimulus(P_BRANCH, 1'($urandom_range(0, 1)), "branch");
    end else begin
      holdAndReset(P_TRAP, "trap");
    end
  endtask

  function automatic logic [6:0] pickOpcode();
    logic [6:0] op;
    case ($urandom_range(0, 9))
      0, 1:    op = OP_R;
      2, 3:    op = OP_I;
      4, 5:    op = OP_LW;
      6, 7:    op = OP_SW;
      8:       op = OP_BEQ;
      default: begin
        op = 7'($urandom_range(0, 127));
        if (op == OP_R || op == OP_I || op == OP_LW || op == OP_SW || op == OP_BEQ) op = 7'b1111111;
      end
    endcase
    return op;
  endfunction

  initial begin
    bit to;
    $display("[TB] start");
    @(posedge clk);
    #1;
    doReset();

    runInstr(OP_R,   3'b000, 1'b0, 0, 0);   // ADD
    runInstr(OP_LW,  3'b010, 1'b0, 0, 3);   // LW, ready after 3 waits
    runInstr(OP_BEQ, 3'b000, 1'b0, 0, 0);
    runInstr(OP_I,   3'b110, 1'b0, 0, 0);   // ORI
    runInstr(OP_R,   3'b000, 1'b1, 1, 0);   // SUB
    runInstr(OP_SW,  3'b010, 1'b0, 2, 1);
    runInstr(7'b1111111, 3'b000, 1'b0, 0, 0);
    runInstr(OP_R,   3'b111, 1'b0, TMO + 2, 0);  // fetch timeout
    runInstr(OP_I,   3'b100, 1'b0, TMO - 1, 0);  // ready on last waiting cycle
    runInstr(OP_LW,  3'b010, 1'b0, 0, TMO + 1);  // data read timeout
    runInstr(OP_SW,  3'b010, 1'b0, 0, TMO - 1);
    runInstr(OP_SW,  3'b010, 1'b0, 0, TMO + 3);  // data write timeout

    // Reset while a store request is still pending.
    opcode_i = OP_SW;
    func3_i  = 3'b010;
    memPhase(P_FETCH, 0, "fetch", to);
    applyStimulus(P_DECODE, 1'b0, "decode");
    applyStimulus(P_MEM_ADDR, 1'b0, "mem_addr");
    applyStimulus(P_MEM_WR, 1'b0, "mem_wr_pending");
    doReset();
    runInstr(OP_R, 3'b001, 1'b0, TMO - 1, 0);

    for (int n = 0; n < 60; n++) begin
      runInstr(pickOpcode(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 19) == 0) ? TMO + 1 : $urandom_range(0, TMO - 1),
               ($urandom_range(0, 19) == 0) ? TMO + 1 : $urandom_range(0, TMO - 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
